ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single-port 4 KiB system RAM between up to N_REQ requesters: the boot loader (ROM→RAM copy), the CPU fetch/execute path and the sprite reader for draw. Each cycle it picks one pending request by round-robin, drives the RAM port from a register and routes read data back to the winner one cycle later. It sits between the requesters and the RAM macro, in place of the current address/data steering muxes.

## Interface
Parameters:
- N_REQ, 3, number of requesters (index 0 = loader, 1 = CPU, 2 = sprite reader).
- AW, 12, RAM address width.
- DW, 8, RAM data width.
- LOCK_TIMEOUT, 16, idle cycles before a held lock is force-released (lock build only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request; held with its fields until granted.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW].
- req_wdata  in  N_REQ*DW  packed write data.
- req_lock  in  N_REQ  keep exclusive ownership after this access (lock build only).
- gnt  out  N_REQ  one-hot, one-cycle pulse: the request was issued to RAM this cycle.
- rvalid  out  N_REQ  one-hot, one-cycle pulse: rdata holds the read result for requester i.
- rdata  out  DW  read data, shared; valid only with rvalid.
- ram_addr  out  AW  registered RAM address.
- ram_din  out  DW  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_dout  in  DW  RAM read data, one cycle after address.

## Operation
- Eligible set = req bits, minus any bit whose gnt is high this cycle (that request is consumed), minus all non-owners while a lock is held.
- Round-robin: search starts at last_winner+1 mod N_REQ; first eligible wins. Reset sets last_winner = N_REQ-1, so requester 0 wins first.
- Winner's fields are registered onto ram_addr/ram_din/ram_we; gnt[winner] is registered at the same time. No eligible request: ram_we=0, gnt=0, ram_addr holds its previous value.
- Reads: a read-issue flag and winner index are pipelined one stage. rvalid[idx] is raised and rdata=ram_dout on the following cycle. Writes produce no rvalid.
- A requester sees gnt at a clock edge. At that edge it drops req or presents its next request. Each requester gets at most one grant every 2 cycles. Different requesters may be granted on consecutive cycles, giving a RAM throughput of one access per cycle.
- Reset (any time): gnt, rvalid, ram_we = 0; ram_addr, ram_din, rdata = 0; last_winner = N_REQ-1; lock released. An in-flight read is dropped with no rvalid.

## Timing
- Cycle t: req[i] sampled and wins. Cycle t+1: gnt[i]=1 and the RAM port is driven. Cycle t+2: rvalid[i]=1 with rdata, for reads.
- Minimum request-to-data latency: 2 cycles. Worst-case wait with no lock: N_REQ-1 other grants.
- Simultaneous requests: one winner per cycle; losers stay pending with no loss.
- No combinational path from req to any output.

## Configuration
- RAM_ARB_LOCK_EN defined:
  - req_lock exists.
  - A granted access with req_lock=1 makes its requester the owner. While an owner exists only it is eligible, and round-robin is suspended.
  - Released by the owner's next granted access with req_lock=0, or after LOCK_TIMEOUT consecutive cycles with the owner's req low (5-bit counter).
  - Used by the loader for atomic block copy.
- Not defined: port absent, no owner or counter logic, pure round-robin.

## Structure
- ram_arb_pkg: default N_REQ/AW/DW, requester index constants REQ_LOADER=0, REQ_CPU=1, REQ_SPRITE=2, LOCK_TIMEOUT default.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are an eligible mask and a start index; outputs are a one-hot winner and a found flag. Instantiated once.

## Test plan
- Single read: REQ_CPU reads 0x200 holding 0xA2 → gnt[1] at t+1, ram_addr=0x200, ram_we=0; rvalid[1] at t+2 with rdata=0xA2.
- All three requesters held from reset → grants 0,1,2,0,1,2 on consecutive cycles with no gaps; each gets one grant per 3 cycles.
- Loader writes 0x55 to 0x300, then the CPU reads 0x300 → the CPU's rvalid carries 0x55.
- Lock build: loader holds req with req_lock=1 for 4 accesses while the CPU requests → the CPU is granted only after the loader's access with req_lock=0. Repeat with the loader dropping req → the CPU is granted 16 cycles later.
- rst_n pulsed low the cycle after a read grant → no rvalid; all outputs 0; the first post-reset grant goes to requester 0.
- Back-to-back from one requester: req[2] held continuously → gnt[2] on alternate cycles only.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants for the system RAM arbiter: default geometry and requester indices.
// The lock feature is enabled by defining RAM_ARB_LOCK_EN.
package ram_arb_pkg;

    localparam int unsigned N_REQ_DEFAULT        = 3;
    localparam int unsigned AW_DEFAULT           = 12;
    localparam int unsigned DW_DEFAULT           = 8;
    localparam int unsigned LOCK_TIMEOUT_DEFAULT = 16;

    localparam int unsigned REQ_LOADER = 0;
    localparam int unsigned REQ_CPU    = 1;
    localparam int unsigned REQ_SPRITE = 2;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after start, wrapping.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT,
    localparam int unsigned IW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] mask,
    input  logic [IW-1:0]    start,
    output logic [N_REQ-1:0] win,
    output logic             found
);

    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = (int'(start) + k) % int'(N_REQ);
            if (!found && mask[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port system RAM; registered RAM port, read data
// routed back two cycles after the request wins. Optional ownership lock via RAM_ARB_LOCK_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT
`ifdef RAM_ARB_LOCK_EN
    , parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic [N_REQ-1:0]    req_lock,
`endif
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_din,
    output logic                ram_we,
    input  logic [DW-1:0]       ram_dout
);

    localparam int unsigned IW = idx_width(N_REQ);

    logic [N_REQ-1:0] gnt_q, rvalid_q, rvalid_d, elig, win_oh;
    logic             found;
    logic [IW-1:0]    last_winner_q, start_idx, win_idx, rd_idx_q;
    logic [AW-1:0]    ram_addr_q, sel_addr;
    logic [DW-1:0]    ram_din_q, sel_wdata;
    logic             ram_we_q, sel_we, rd_issue_q;

`ifdef RAM_ARB_LOCK_EN
    logic          own_valid_q, own_valid_d, sel_lock;
    logic [IW-1:0] owner_q, owner_d;
    logic [4:0]    idle_cnt_q, idle_cnt_d;
`endif

    assign start_idx = (last_winner_q == IW'(N_REQ - 1)) ? '0 : last_winner_q + 1'b1;

    // A request whose grant is showing this cycle was already issued; do not issue it twice.
    always_comb begin
        elig = req & ~gnt_q;
`ifdef RAM_ARB_LOCK_EN
        if (own_valid_q) begin
            elig = elig & (N_REQ'(1) << owner_q);
        end
`endif
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .mask  (elig),
        .start (start_idx),
        .win   (win_oh),
        .found (found)
    );

    always_comb begin
        win_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
`ifdef RAM_ARB_LOCK_EN
        sel_lock  = 1'b0;
`endif
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_oh[i]) begin
                win_idx   = IW'(i);
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_we    = req_we[i];
`ifdef RAM_ARB_LOCK_EN
                sel_lock  = req_lock[i];
`endif
            end
        end
    end

    always_comb begin
        rvalid_d = '0;
        if (rd_issue_q) begin
            rvalid_d[rd_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q         <= '0;
            rvalid_q      <= '0;
            ram_addr_q    <= '0;
            ram_din_q     <= '0;
            ram_we_q      <= 1'b0;
            rd_issue_q    <= 1'b0;
            rd_idx_q      <= '0;
            last_winner_q <= IW'(N_REQ - 1);
        end else begin
            gnt_q      <= win_oh;
            ram_we_q   <= found & sel_we;
            rd_issue_q <= found & ~sel_we;
            rd_idx_q   <= win_idx;
            rvalid_q   <= rvalid_d;
            if (found) begin
                ram_addr_q    <= sel_addr;
                ram_din_q     <= sel_wdata;
                last_winner_q <= win_idx;
            end
        end
    end

`ifdef RAM_ARB_LOCK_EN
    // While locked only the owner can win, so any grant in that state is the owner's.
    always_comb begin
        own_valid_d = own_valid_q;
        owner_d     = owner_q;
        idle_cnt_d  = idle_cnt_q;
        if (own_valid_q) begin
            if (req[owner_q]) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == 5'(LOCK_TIMEOUT - 1)) begin
                own_valid_d = 1'b0;
                idle_cnt_d  = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 5'd1;
            end
        end
        if (found) begin
            if (sel_lock) begin
                own_valid_d = 1'b1;
                owner_d     = win_idx;
                idle_cnt_d  = '0;
            end else if (own_valid_q) begin
                own_valid_d = 1'b0;
                idle_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_valid_q <= 1'b0;
            owner_q     <= '0;
            idle_cnt_q  <= '0;
        end else begin
            own_valid_q <= own_valid_d;
            owner_q     <= owner_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end
`endif

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign rdata    = (|rvalid_q) ? ram_dout : '0;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a synchronous 4 KiB RAM model.
// Lock scenarios are compiled in when RAM_ARB_LOCK_EN is defined.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    logic [N-1:0]    req_lock = '0;
`endif
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, ram_din;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [DW-1:0]   ram_dout = '0;

    logic [DW-1:0]   mem [0:4095];

    int n_checks = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef RAM_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) step();
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req[i]                = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (2) step();
        n_checks++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        n_checks++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL reset_rvalid: got %b want 000", rvalid); end
        n_checks++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
        n_checks++; if (ram_addr !== 12'h000) begin n_bad++; $display("FAIL reset_addr: got %h want 000", ram_addr); end
        n_checks++; if (ram_din !== 8'h00) begin n_bad++; $display("FAIL reset_din: got %h want 00", ram_din); end
        n_checks++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single_read();
        set_req(REQ_CPU, 1'b0, 12'h200, 8'h00);
        step();
        n_checks++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL read_gnt: got %b want 010", gnt); end
        n_checks++; if (ram_addr !== 12'h200) begin n_bad++; $display("FAIL read_addr: got %h want 200", ram_addr); end
        n_checks++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL read_we: got %b want 0", ram_we); end
        req[REQ_CPU] = 1'b0;
        step();
        n_checks++; if (rvalid !== 3'b010) begin n_bad++; $display("FAIL read_rvalid: got %b want 010", rvalid); end
        n_checks++; if (rdata !== 8'hA2) begin n_bad++; $display("FAIL read_rdata: got %h want a2", rdata); end
        n_checks++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL read_gnt_gone: got %b want 000", gnt); end
        step();
        n_checks++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL read_rvalid_gone: got %b want 000", rvalid); end
        idle(2);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        rst_n = 1'b0;
        set_req(REQ_LOADER, 1'b0, 12'h100, 8'h00);
        set_req(REQ_CPU, 1'b0, 12'h101, 8'h00);
        set_req(REQ_SPRITE, 1'b0, 12'h102, 8'h00);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_g = 3'b001 << (k % 3);
            n_checks++;
            if (gnt !== exp_g) begin
                n_bad++;
                $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_g);
            end
        end
        idle(3);
    endtask

    task automatic test_write_then_read();
        set_req(REQ_LOADER, 1'b1, 12'h300, 8'h55);
        step();
        n_checks++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL wr_gnt: got %b want 001", gnt); end
        n_checks++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL wr_we: got %b want 1", ram_we); end
        n_checks++; if (ram_addr !== 12'h300) begin n_bad++; $display("FAIL wr_addr: got %h want 300", ram_addr); end
        n_checks++; if (ram_din !== 8'h55) begin n_bad++; $display("FAIL wr_din: got %h want 55", ram_din); end
        req[REQ_LOADER] = 1'b0;
        step();
        n_checks++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL wr_no_rvalid: got %b want 000", rvalid); end
        n_checks++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL idle_we: got %b want 0", ram_we); end
        n_checks++; if (ram_addr !== 12'h300) begin n_bad++; $display("FAIL idle_addr_hold: got %h want 300", ram_addr); end
        set_req(REQ_CPU, 1'b0, 12'h300, 8'h00);
        step();
        n_checks++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL rd300_gnt: got %b want 010", gnt); end
        req[REQ_CPU] = 1'b0;
        step();
        n_checks++; if (rvalid !== 3'b010) begin n_bad++; $display("FAIL rd300_rvalid: got %b want 010", rvalid); end
        n_checks++; if (rdata !== 8'h55) begin n_bad++; $display("FAIL rd300_rdata: got %h want 55", rdata); end
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        set_req(REQ_CPU, 1'b0, 12'h200, 8'h00);
        step();
        n_checks++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL rst_pre_gnt: got %b want 010", gnt); end
        req[REQ_CPU] = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL rst_gnt: got %b want 000", gnt); end
        n_checks++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", ram_we); end
        n_checks++; if (ram_addr !== 12'h000) begin n_bad++; $display("FAIL rst_addr: got %h want 000", ram_addr); end
        n_checks++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", rdata); end
        set_req(REQ_LOADER, 1'b0, 12'h010, 8'h00);
        set_req(REQ_CPU, 1'b0, 12'h011, 8'h00);
        set_req(REQ_SPRITE, 1'b0, 12'h012, 8'h00);
        step();
        n_checks++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL rst_rvalid: got %b want 000", rvalid); end
        rst_n = 1'b1;
        step();
        n_checks++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL rst_first_gnt: got %b want 001", gnt); end
        n_checks++; if (rvalid !== 3'b000) begin n_bad++; $display("FAIL rst_dropped_read: got %b want 000", rvalid); end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_g, exp_v;
        set_req(REQ_SPRITE, 1'b0, 12'h200, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_g = (k % 2 == 1) ? 3'b100 : 3'b000;
            exp_v = (k % 2 == 0) ? 3'b100 : 3'b000;
            n_checks++;
            if (gnt !== exp_g) begin
                n_bad++;
                $display("FAIL b2b_gnt[%0d]: got %b want %b", k, gnt, exp_g);
            end
            n_checks++;
            if (rvalid !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_rvalid[%0d]: got %b want %b", k, rvalid, exp_v);
            end
            if (k % 2 == 0) begin
                n_checks++;
                if (rdata !== 8'hA2) begin
                    n_bad++;
                    $display("FAIL b2b_rdata[%0d]: got %h want a2", k, rdata);
                end
            end
        end
        idle(3);
    endtask

`ifdef RAM_ARB_LOCK_EN
    task automatic test_lock_release();
        int ldr = 0;
        int last_ldr = -1;
        int cpu_cyc = -1;
        int ldr_before = -1;
        set_req(REQ_LOADER, 1'b1, 12'h400, 8'h11);
        req_lock[REQ_LOADER] = 1'b1;
        for (int c = 1; c <= 40 && cpu_cyc < 0; c++) begin
            step();
            if (gnt[REQ_LOADER]) begin
                ldr++;
                last_ldr = c;
                req_addr[REQ_LOADER*AW +: AW] = 12'h400 + 12'(ldr);
                // Four locked accesses, then one unlocked access that releases ownership.
                req_lock[REQ_LOADER] = (ldr < 4);
                if (ldr >= 5) req[REQ_LOADER] = 1'b0;
            end
            if (gnt[REQ_CPU]) begin
                cpu_cyc = c;
                ldr_before = ldr;
                req[REQ_CPU] = 1'b0;
            end
            if (c == 1) set_req(REQ_CPU, 1'b0, 12'h200, 8'h00);
        end
        n_checks++; if (cpu_cyc < 0) begin n_bad++; $display("FAIL lock_cpu_grant: got none want a grant"); end
        n_checks++; if (ldr_before !== 5) begin n_bad++; $display("FAIL lock_loader_count: got %0d want 5", ldr_before); end
        n_checks++; if (cpu_cyc !== last_ldr + 1) begin n_bad++; $display("FAIL lock_cpu_cycle: got %0d want %0d", cpu_cyc, last_ldr + 1); end
        req = '0;
        req_lock = '0;
        idle(3);
    endtask

    task automatic test_lock_timeout();
        int cpu_cyc = -1;
        set_req(REQ_LOADER, 1'b1, 12'h500, 8'h22);
        req_lock[REQ_LOADER] = 1'b1;
        step();
        n_checks++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL lto_loader_gnt: got %b want 001", gnt); end
        req[REQ_LOADER] = 1'b0;
        req_lock[REQ_LOADER] = 1'b0;
        set_req(REQ_CPU, 1'b0, 12'h200, 8'h00);
        for (int c = 1; c <= 40 && cpu_cyc < 0; c++) begin
            step();
            if (gnt[REQ_CPU]) begin
                cpu_cyc = c;
                req[REQ_CPU] = 1'b0;
            end
        end
        // 16 idle owner cycles release the lock, the CPU wins next cycle and sees gnt one later.
        n_checks++; if (cpu_cyc !== 17) begin n_bad++; $display("FAIL lto_cpu_cycle: got %0d want 17", cpu_cyc); end
        idle(3);
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'hA2;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_then_read();
        test_reset_mid_read();
        test_back_to_back();
`ifdef RAM_ARB_LOCK_EN
        test_lock_release();
        test_lock_timeout();
`endif
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
